// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift/compare ops plus
// iterative radix-2 MUL/DIVU/REMU, with registered result and status flags.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpNor  = 4'd4;
    localparam logic [3:0] OpSltu = 4'd5;
    localparam logic [3:0] OpSlt  = 4'd6;
    localparam logic [3:0] OpXor  = 4'd7;
    localparam logic [3:0] OpSll  = 4'd8;
    localparam logic [3:0] OpSrl  = 4'd9;
    localparam logic [3:0] OpSra  = 4'd10;
    localparam logic [3:0] OpMul  = 4'd11;
    localparam logic [3:0] OpDivu = 4'd12;
    localparam logic [3:0] OpRemu = 4'd13;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [SHW-1:0]   count_q, count_d;
    // opa: multiplicand (MUL) or dividend/quotient shift register (DIV)
    // opb: multiplier (MUL) or divisor (DIV); acc: product or partial remainder
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             div_zero_q, div_zero_d;
    logic             illegal_q, illegal_d;

    // Single-cycle datapath on the live inputs, sampled only at the accept edge
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] s_result;
    logic             s_carry, s_overflow, s_illegal, s_iter;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign diff    = a - b;
    assign shamt   = b[SHW-1:0];
    assign s_iter  = (alu_op == OpMul) || (alu_op == OpDivu) || (alu_op == OpRemu);

    always_comb begin
        s_result   = '0;
        s_carry    = 1'b0;
        s_overflow = 1'b0;
        s_illegal  = 1'b0;
        case (alu_op)
            OpAdd: begin
                s_result   = sum_ext[WIDTH-1:0];
                s_carry    = sum_ext[WIDTH];
                s_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                s_result   = diff;
                s_carry    = (a >= b);
                s_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd:  s_result = a & b;
            OpOr:   s_result = a | b;
            OpNor:  s_result = ~(a | b);
            OpSltu: s_result = WIDTH'(a < b);
            OpSlt:  s_result = WIDTH'($signed(a) < $signed(b));
            OpXor:  s_result = a ^ b;
            OpSll:  s_result = a << shamt;
            OpSrl:  s_result = a >> shamt;
            OpSra:  s_result = $unsigned($signed(a) >>> shamt);
            OpMul, OpDivu, OpRemu: s_result = '0;
            default: s_illegal = 1'b1;
        endcase
    end

    // One radix-2 step of the iterative units
    logic [WIDTH-1:0] mul_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    assign mul_next  = acc_q + (opb_q[0] ? opa_q : '0);
    assign div_shift = {acc_q, opa_q[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, opb_q};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    // Remainder is always below the divisor, so the top bit is dropped safely
    assign rem_next  = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {opa_q[WIDTH-2:0], div_ge};
    assign last_step = (count_q == SHW'(WIDTH - 1));

    logic [WIDTH-1:0] iter_final;

    always_comb begin
        case (op_q)
            OpMul:   iter_final = mul_next;
            OpDivu:  iter_final = quo_next;
            default: iter_final = rem_next;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        count_d    = count_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        div_zero_d = div_zero_q;
        illegal_d  = illegal_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d       = alu_op;
                    zero_d     = 1'b0;
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    div_zero_d = 1'b0;
                    illegal_d  = 1'b0;
                    if (s_iter) begin
                        opa_d   = a;
                        opb_d   = b;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = StBusy;
                    end else begin
                        result_d   = s_result;
                        zero_d     = (s_result == '0);
                        carry_d    = s_carry;
                        overflow_d = s_overflow;
                        illegal_d  = s_illegal;
                        state_d    = StDone;
                    end
                end
            end
            StBusy: begin
                count_d = count_q + SHW'(1);
                if (op_q == OpMul) begin
                    acc_d = mul_next;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    // A zero divisor naturally yields all-ones quotient and remainder = a
                    acc_d = rem_next;
                    opa_d = quo_next;
                end
                if (last_step) begin
                    result_d   = iter_final;
                    zero_d     = (iter_final == '0);
                    div_zero_d = (op_q != OpMul) && (opb_q == '0);
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= '0;
            count_q    <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            count_q    <= count_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            div_zero_q <= div_zero_d;
            illegal_q  <= illegal_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;
    assign illegal   = illegal_q;

endmodule
